// File: rtl/bitstream_serializer_if.sv
// Configuration-stream link bundle between a loader/harness and the serializer.
// Ports: CfgIn/CfgLoad/TxPause/BitstreamLoaded in, serial data/valid and status out.
// slave = serializer side, master = loader/harness side.
interface bitstream_serializer_if #(
  parameter int CFG_SIZE = 64
);
  logic [CFG_SIZE-1:0] CfgIn;
  logic                CfgLoad;
  logic                TxPause;
  logic                BitstreamLoaded;
  logic                BitStreamSerialOut;
  logic                BitStreamValid;
  logic                Busy;
  logic                TxDone;
  logic                TxError;

  modport slave (
    input  CfgIn, CfgLoad, TxPause, BitstreamLoaded,
    output BitStreamSerialOut, BitStreamValid, Busy, TxDone, TxError
  );

  modport master (
    output CfgIn, CfgLoad, TxPause, BitstreamLoaded,
    input  BitStreamSerialOut, BitStreamValid, Busy, TxDone, TxError
  );
endinterface

// File: rtl/bitstream_serializer.sv
// Purpose: encrypt a parallel FRU configuration word and shift it out MSB-first, then await the FRU load ack.
// Latency: first serial bit valid 1 cycle after CfgLoad; one bit per unpaused cycle; ack seen 3 cycles after BitstreamLoaded rises.
// Backpressure: TxPause stalls the shifter (Valid low, no bit consumed); CfgLoad ignored while Busy.
// Ports: clk, rst (sync, active-high); bus.slave carries CfgIn/CfgLoad/TxPause/BitstreamLoaded in and
//        BitStreamSerialOut/BitStreamValid/Busy/TxDone/TxError out.
module bitstream_serializer #(
  parameter int          CFG_SIZE    = 64,
  parameter logic [31:0] ENCRYPT_KEY = 32'hDEAD_BEEF,
  parameter bit          ENCRYPT_EN  = 1'b1,
  parameter int          ACK_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  bitstream_serializer_if.slave  bus
);

  localparam int CW = $clog2(CFG_SIZE + 1);
  // A zero timeout still needs a 1-bit counter to keep the declarations legal.
  localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] BITS_LOAD = CW'(CFG_SIZE);
  localparam logic [CW-1:0] BITS_LAST = CW'(1);
  localparam logic [TW-1:0] T_LAST    = (ACK_TIMEOUT > 0) ? TW'(ACK_TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_WAIT_ACK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_q;
  logic [CFG_SIZE-1:0] shreg_q;
  logic [CW-1:0]       bitcnt_q;
  logic [TW-1:0]       tcnt_q;
  logic                ack_s1_q;
  logic                ack_s2_q;
  logic                ack_dly_q;
  logic                done_q;
  logic                err_q;

  logic [CFG_SIZE-1:0] enc_d;
  logic                shift_en;
  logic                ack_rise;

  // Key repeats every 32 bits starting at bit 0, matching the FRU decryptor.
  always_comb begin
    enc_d = bus.CfgIn;
    if (ENCRYPT_EN) begin
      for (int i = 0; i < CFG_SIZE; i++) begin
        enc_d[i] = bus.CfgIn[i] ^ ENCRYPT_KEY[i % 32];
      end
    end
  end

  assign shift_en = (state_q == S_SHIFT) && !bus.TxPause;
  // Only a fresh rising edge counts, so a level left high by a previous load is not an ack.
  assign ack_rise = ack_s2_q & ~ack_dly_q;

  assign bus.BitStreamValid     = shift_en;
  assign bus.BitStreamSerialOut = shreg_q[CFG_SIZE-1] & shift_en;
  assign bus.Busy               = (state_q == S_SHIFT) || (state_q == S_WAIT_ACK);
  assign bus.TxDone             = done_q;
  assign bus.TxError            = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      tcnt_q    <= '0;
      ack_s1_q  <= 1'b0;
      ack_s2_q  <= 1'b0;
      ack_dly_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // BitstreamLoaded comes from the FRU domain: two-flop synchronizer plus an edge-detect flop.
      ack_s1_q  <= bus.BitstreamLoaded;
      ack_s2_q  <= ack_s1_q;
      ack_dly_q <= ack_s2_q;

      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.CfgLoad) begin
            shreg_q  <= enc_d;
            bitcnt_q <= BITS_LOAD;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            state_q  <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (!bus.TxPause) begin
            shreg_q  <= shreg_q << 1;
            bitcnt_q <= bitcnt_q - 1'b1;
            // Leave SHIFT on the edge that consumes the last bit so Valid never overruns.
            if (bitcnt_q == BITS_LAST) begin
              tcnt_q <= '0;
              if (ACK_TIMEOUT == 0) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                state_q <= S_WAIT_ACK;
              end
            end
          end
        end

        S_WAIT_ACK: begin
          tcnt_q <= tcnt_q + 1'b1;
          // An ack on the final timeout cycle still counts as success.
          if (ack_rise) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (tcnt_q == T_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_ERROR;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_serializer.sv
// Scoreboard bench for bitstream_serializer: two instances (encrypted 8-bit with a 4-cycle ack
// timeout, plaintext 12-bit with no ack wait). Stimulus pushes expected frames/outcomes; a negedge
// monitor reassembles serial frames and status transitions and compares them.
module tb_bitstream_serializer;

  localparam int          WA     = 8;
  localparam int          WB     = 12;
  localparam logic [31:0] KEY_A  = 32'h0000_00FF;
  localparam logic [31:0] KEY_B  = 32'hDEAD_BEEF;
  localparam int          TO_A   = 4;
  localparam int          TO_B   = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bitstream_serializer_if #(.CFG_SIZE(WA)) ifa ();
  bitstream_serializer_if #(.CFG_SIZE(WB)) ifb ();

  bitstream_serializer #(
    .CFG_SIZE(WA), .ENCRYPT_KEY(KEY_A), .ENCRYPT_EN(1'b1), .ACK_TIMEOUT(TO_A)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  bitstream_serializer #(
    .CFG_SIZE(WB), .ENCRYPT_KEY(KEY_B), .ENCRYPT_EN(1'b0), .ACK_TIMEOUT(TO_B)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int tests  = 0;
  int failed = 0;

  typedef struct { int w; logic [11:0] data; } frame_t;
  typedef struct { int w; bit done; int edges; } outc_t;
  frame_t fq[$];
  outc_t  oq[$];

  logic mv[2], ms[2], mb[2], md[2], me[2];
  assign mv[0] = ifa.BitStreamValid;   assign mv[1] = ifb.BitStreamValid;
  assign ms[0] = ifa.BitStreamSerialOut; assign ms[1] = ifb.BitStreamSerialOut;
  assign mb[0] = ifa.Busy;             assign mb[1] = ifb.Busy;
  assign md[0] = ifa.TxDone;           assign md[1] = ifb.TxDone;
  assign me[0] = ifa.TxError;          assign me[1] = ifb.TxError;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input int w);
    return (w == 0) ? WA : WB;
  endfunction

  // Reference: the key tiled every 32 bits from bit 0, XORed over the word; instance B is plaintext.
  function automatic logic [11:0] model_frame(input int w, input logic [11:0] cfg);
    logic [63:0] krep;
    krep = {KEY_A, KEY_A};
    if (w == 0) return (cfg ^ krep[11:0]) & 12'h0FF;
    return cfg;
  endfunction

  // ---------------- monitor ----------------
  int          nb[2]       = '{0, 0};
  logic [11:0] acc[2]      = '{12'h0, 12'h0};
  int          last_idx[2] = '{0, 0};
  bit          pbusy[2]    = '{1'b0, 1'b0};
  int          sidx        = 0;

  always @(negedge clk) begin
    frame_t f;
    outc_t  o;
    sidx++;
    for (int w = 0; w < 2; w++) begin
      if (rst) begin
        // An aborted stream is never resumed: drop its pending expectations.
        if (nb[w] != 0) begin
          if (fq.size() > 0) void'(fq.pop_front());
          if (oq.size() > 0) void'(oq.pop_front());
        end
        nb[w] = 0; acc[w] = '0; pbusy[w] = 1'b0;
      end else begin
        if (!mv[w]) chk("out_low_when_invalid", ms[w], 1'b0);
        if (mv[w]) begin
          if (nb[w] == 0 && fq.size() == 0) begin
            chk("unexpected_valid_bit", 1, 0);
          end else begin
            acc[w] = {acc[w][10:0], ms[w]};
            nb[w]++;
            last_idx[w] = sidx;
            if (nb[w] == size_of(w)) begin
              f = fq.pop_front();
              chk("frame_instance", w, f.w);
              chk("frame_data", acc[w], f.data);
              nb[w] = 0; acc[w] = '0;
            end
          end
        end
        if (pbusy[w] && !mb[w]) begin
          if (oq.size() == 0) begin
            chk("unexpected_outcome", 1, 0);
          end else begin
            o = oq.pop_front();
            chk("outcome_instance", w, o.w);
            chk("tx_done", md[w], o.done);
            chk("tx_error", me[w], !o.done);
            // Edges counted from the edge that consumed the last bit.
            chk("outcome_latency", sidx - last_idx[w] - 1, o.edges);
          end
        end
        pbusy[w] = mb[w];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input int w, input bit l, input logic [11:0] c);
    if (w == 0) begin ifa.CfgLoad = l; ifa.CfgIn = c[7:0]; end
    else        begin ifb.CfgLoad = l; ifb.CfgIn = c;      end
  endtask

  task automatic set_pause(input int w, input bit p);
    if (w == 0) ifa.TxPause = p; else ifb.TxPause = p;
  endtask

  task automatic set_ack(input int w, input bit a);
    if (w == 0) ifa.BitstreamLoaded = a; else ifb.BitstreamLoaded = a;
  endtask

  task automatic wait_idle(input int w);
    for (int i = 0; i < 40 && mb[w]; i++) tick();
    chk("idle_wait_bound", mb[w], 1'b0);
  endtask

  // ack_k > 0: BitstreamLoaded rises so the first sync flop sees it (ack_k) edges after the
  // last-bit edge; 0 = never raised. hold_hi: ack already high from before the load.
  task automatic send(input int w, input logic [11:0] cfg, input int pause_pct, input int ack_k,
                      input int pause_at, input bit busy_load, input bit hold_hi);
    int  to, n, sent, gap, guard;
    bit  done, p, bl_done;
    int  edges;
    to = (w == 0) ? TO_A : TO_B;
    n  = size_of(w);
    // Ack path: two synchronizer edges plus the acting edge, so a rise first sampled at
    // edge k completes at edge k+2; it wins if that is no later than the timeout edge.
    if (to == 0)                                    begin done = 1'b1; edges = 0;        end
    else if (!hold_hi && ack_k > 0 && ack_k + 2 <= to) begin done = 1'b1; edges = ack_k + 2; end
    else                                            begin done = 1'b0; edges = to;       end

    fq.push_back('{w, model_frame(w, cfg)});
    oq.push_back('{w, done, edges});

    set_load(w, 1'b1, cfg);
    tick();
    set_load(w, 1'b0, cfg);
    chk("load_busy", mb[w], 1'b1);
    chk("load_clears_done", md[w], 1'b0);
    chk("load_clears_error", me[w], 1'b0);

    sent = 0; gap = 0; guard = 0; bl_done = 1'b0;
    while (sent < n && guard < 1000) begin
      guard++;
      if (pause_at >= 0 && sent == pause_at && gap < 3) begin p = 1'b1; gap++; end
      else p = ($urandom_range(0, 99) < pause_pct);
      set_pause(w, p);
      if (p && pause_at >= 0) begin
        #1;
        chk("pause_valid_low", mv[w], 1'b0);
        chk("pause_out_low", ms[w], 1'b0);
      end
      if (busy_load && sent == 3 && !bl_done) begin
        set_load(w, 1'b1, 12'h000);
        bl_done = 1'b1;
      end
      tick();
      set_load(w, 1'b0, cfg);
      if (!p) sent++;
    end
    chk("shift_guard", sent, n);
    set_pause(w, 1'b0);

    if (to > 0) begin
      chk("wait_ack_busy", mb[w], 1'b1);
      chk("wait_ack_valid_low", mv[w], 1'b0);
    end else begin
      chk("no_ack_busy_low", mb[w], 1'b0);
      chk("no_ack_done_now", md[w], 1'b1);
    end

    if (ack_k > 0) begin
      repeat (ack_k - 1) tick();
      set_ack(w, 1'b1);
    end
    wait_idle(w);
    set_ack(w, 1'b0);
    repeat (4) tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    set_load(0, 1'b0, 12'h0); set_load(1, 1'b0, 12'h0);
    set_pause(0, 1'b0); set_pause(1, 1'b0);
    set_ack(0, 1'b0); set_ack(1, 1'b0);
    tick(); tick();
    for (int w = 0; w < 2; w++) begin
      chk("rst_valid", mv[w], 1'b0);
      chk("rst_out", ms[w], 1'b0);
      chk("rst_busy", mb[w], 1'b0);
      chk("rst_done", md[w], 1'b0);
      chk("rst_error", me[w], 1'b0);
    end
    rst = 1'b0;
    tick();

    // Encrypted A5 -> 5A, ack right after the last bit.
    send(0, 12'h0A5, 0, 1, -1, 1'b0, 1'b0);
    // Load attempt during SHIFT is ignored; ack lands exactly on the timeout edge (done wins).
    send(0, 12'h0A5, 0, 2, -1, 1'b1, 1'b0);
    // Reload from DONE, no ack -> timeout.
    send(0, 12'h03C, 0, 0, -1, 1'b0, 1'b0);
    // Ack one edge too late -> timeout.
    send(0, 12'h0C3, 0, 3, -1, 1'b0, 1'b0);
    // Ack level already high before the load: no edge, so timeout.
    set_ack(0, 1'b1);
    repeat (4) tick();
    send(0, 12'h081, 0, 1, -1, 1'b0, 1'b1);

    // Reset after three bits aborts the stream.
    fq.push_back('{0, model_frame(0, 12'h0A5)});
    oq.push_back('{0, 1'b0, 0});
    set_load(0, 1'b1, 12'h0A5);
    tick();
    set_load(0, 1'b0, 12'h0A5);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("midrst_valid", mv[0], 1'b0);
    chk("midrst_out", ms[0], 1'b0);
    chk("midrst_busy", mb[0], 1'b0);
    chk("midrst_done", md[0], 1'b0);
    chk("midrst_error", me[0], 1'b0);
    rst = 1'b0;
    tick();
    send(0, 12'h0A5, 0, 1, -1, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      send(0, 12'($urandom_range(0, 255)), 30, $urandom_range(0, 6), -1, 1'b0, 1'b0);
    end

    // Plaintext instance, 3-cycle pause after the 2nd bit, ack never raised.
    send(1, 12'hF0A, 0, 0, 2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      send(1, 12'($urandom_range(0, 4095)), 30, $urandom_range(0, 4), -1, 1'b0, 1'b0);
    end

    repeat (5) tick();
    chk("frames_left", fq.size(), 0);
    chk("outcomes_left", oq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Absolute time bound so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
